cam_pattern_gen: RTL and testbench

- Synthesisable OV5642-style sensor emulator: the transmitting end of the camera video port (cam_pclk, vsync, href, 8-bit data).
- Generates YUV422 byte-serial test frames so the camera capture path can be exercised in the lab and in simulation without a sensor.
- The capture path is Camera_buffer write gating plus the Y/chroma phase toggle.
- Instantiated in place of the sensor pins (cam_vsync_i, cam_href_i, cam_din) or in the bench.

---
 rtl/cam_pattern_gen.sv | 212 +++++++++++++++++++++
 tb/tb_cam_pattern_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - OV5642-style YUV422 test-pattern sensor emulator
//
// Drives the camera video port (vsync/href/byte data) with synthetic frames
// so the capture path can run without a sensor attached.
//
// Ports:
//   cam_pclk    in   pixel/byte clock, all logic on the rising edge
//   rst         in   asynchronous, active-high reset
//   enable      in   run request, sampled at frame boundaries only
//   mode[1:0]   in   pattern select, latched at frame start
//   vsync_o     out  frame sync, active high
//   href_o      out  line valid, active high
//   data_o[7:0] out  YUV422 byte stream, 8'h00 while href_o is low
//   frame_done  out  one-cycle pulse on the last cycle of the front porch
//   busy        out  high for the whole frame
//
// Optional build macro: CAM_PG_FRAME_TAG_EN (tags line 0 with A5,frame_cnt).

module cam_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       cam_pclk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       frame_done,
  output logic       busy
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VW       = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int BW       = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;
  logic [HW-1:0]   r_hcnt;
  logic [VW-1:0]   r_vline;
  logic [VW-1:0]   w_sect_last;
  logic            w_line_end;
  logic            w_sect_end;
  logic            w_frame_end;
  logic [1:0]      r_mode;
  logic [7:0]      r_frame_cnt;
  logic [BW-1:0]   r_bar_cnt;
  logic [2:0]      r_bar;
  logic            w_href;
  logic [7:0]      w_x;
  logic [7:0]      w_y;
  logic [7:0]      w_luma;
  logic [7:0]      w_byte;
  logic            r_vsync;
  logic            r_href;
  logic [7:0]      r_data;
  logic            r_frame_done;
  logic            r_busy;

  // Last line index of the section the FSM is currently in.
  always_comb begin
    w_sect_last = '0;
    case (r_state)
      S_VSYNC:  w_sect_last = VW'(VSYNC_LINES - 1);
      S_VBACK:  w_sect_last = VW'(V_BACK - 1);
      S_ACTIVE: w_sect_last = VW'(V_ACTIVE - 1);
      S_VFRONT: w_sect_last = VW'(V_FRONT - 1);
      default:  w_sect_last = '0;
    endcase
  end

  assign w_line_end  = (r_hcnt == HW'(LINE_LEN - 1));
  assign w_sect_end  = w_line_end && (r_vline == w_sect_last);
  assign w_frame_end = (r_state == S_VFRONT) && w_sect_end;

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // w_start marks the edge on which a new frame begins and mode is latched.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_VSYNC;
          w_start     = 1'b1;
        end
      end
      S_VSYNC:  if (w_sect_end) w_state_nxt = S_VBACK;
      S_VBACK:  if (w_sect_end) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_sect_end) w_state_nxt = S_VFRONT;
      S_VFRONT: begin
        if (w_sect_end) begin
          if (enable) begin
            w_state_nxt = S_VSYNC;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_href = (r_state == S_ACTIVE) && (r_hcnt < HW'(2 * H_ACTIVE));

  // Line/section counters, latched mode, frame counter and the colour-bar
  // tracker. The bar index is stepped incrementally so no divider is needed.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_vline     <= '0;
      r_mode      <= 2'd0;
      r_frame_cnt <= 8'd0;
      r_bar_cnt   <= '0;
      r_bar       <= 3'd0;
    end else begin
      if (r_state == S_IDLE) begin
        r_hcnt  <= '0;
        r_vline <= '0;
      end else begin
        r_hcnt <= w_line_end ? '0 : r_hcnt + 1'b1;
        if (w_sect_end)      r_vline <= '0;
        else if (w_line_end) r_vline <= r_vline + 1'b1;
      end

      if (w_start)     r_mode      <= mode;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;

      if ((r_state != S_ACTIVE) || w_line_end) begin
        r_bar_cnt <= '0;
        r_bar     <= 3'd0;
      end else if (w_href && r_hcnt[0]) begin
        if (r_bar_cnt == BW'(BAR_W - 1)) begin
          r_bar_cnt <= '0;
          r_bar     <= r_bar + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 1'b1;
        end
      end
    end
  end

  assign w_x = 8'(r_hcnt >> 1);
  assign w_y = 8'(r_vline);

  always_comb begin
    w_luma = 8'h00;
    case (r_mode)
      2'd0:    w_luma = {r_bar, 5'b0};
      2'd1:    w_luma = w_x;
      2'd2:    w_luma = r_frame_cnt;
      default: w_luma = (((w_x ^ w_y) & 8'h08) != 8'h00) ? 8'hFF : 8'h00;
    endcase
  end

  // Even bytes are chroma (fixed mid-scale), odd bytes luma.
  always_comb begin
    w_byte = r_hcnt[0] ? w_luma : 8'h80;
`ifdef CAM_PG_FRAME_TAG_EN
    if (w_y == 8'd0) begin
      if (r_hcnt == HW'(0)) w_byte = 8'hA5;
      if (r_hcnt == HW'(1)) w_byte = r_frame_cnt;
    end
`endif
  end

  // Outputs are registered from the current state, so the whole port lags
  // the internal counters by exactly one cycle and stays aligned with itself.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_vsync      <= (r_state == S_VSYNC);
      r_href       <= w_href;
      r_data       <= w_href ? w_byte : 8'h00;
      r_frame_done <= w_frame_end;
      r_busy       <= (r_state != S_IDLE);
    end
  end

  assign vsync_o    = r_vsync;
  assign href_o     = r_href;
  assign data_o     = r_data;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb/tb_cam_pattern_gen.sv - scoreboard bench for cam_pattern_gen
module tb_cam_pattern_gen;

  localparam int H_ACTIVE    = 8;
  localparam int H_BLANK     = 4;
  localparam int V_ACTIVE    = 4;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LEN   = LINE_LEN * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);

  logic       cam_pclk = 1'b0;
  logic       rst      = 1'b1;
  logic       enable   = 1'b0;
  logic [1:0] mode     = 2'd0;
  logic       vsync_o;
  logic       href_o;
  logic [7:0] data_o;
  logic       frame_done;
  logic       busy;

  cam_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .cam_pclk(cam_pclk), .rst(rst), .enable(enable), .mode(mode),
    .vsync_o(vsync_o), .href_o(href_o), .data_o(data_o),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 cam_pclk = ~cam_pclk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         model_fcnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference byte for pixel-byte b of active line y.
  function automatic logic [7:0] model_byte(input int m, input int fcnt, input int b, input int y);
    int x;
    x = b / 2;
`ifdef CAM_PG_FRAME_TAG_EN
    if (y == 0 && b == 0) return 8'hA5;
    if (y == 0 && b == 1) return 8'(fcnt % 256);
`endif
    if (b % 2 == 0) return 8'h80;
    case (m)
      0:       return 8'(((x / (H_ACTIVE / 8)) % 8) * 32);
      1:       return 8'(x % 256);
      2:       return 8'(fcnt % 256);
      default: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic push_frame(input int m);
    for (int y = 0; y < V_ACTIVE; y++)
      for (int b = 0; b < 2 * H_ACTIVE; b++)
        exp_q.push_back(model_byte(m, model_fcnt, b, y));
  endtask

  // Monitor: pops expected bytes whenever href_o is high and checks framing.
  logic prev_vs = 1'b0;
  logic prev_href = 1'b0;
  int   vs_len = 0;
  int   h_len = 0;
  int   lines = 0;
  int   fpos = 0;

  always @(negedge cam_pclk) begin
    if (rst) begin
      prev_vs = 1'b0; prev_href = 1'b0;
      vs_len = 0; h_len = 0; lines = 0; fpos = 0;
    end else begin
      check("bus_rules", ((vsync_o && href_o) || (!href_o && data_o != 8'h00)) ? 1 : 0, 0);
      if (href_o) begin
        if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
        else                   check("data_byte", int'(data_o), int'(exp_q.pop_front()));
      end
      if (vsync_o && !prev_vs) fpos = 1;
      else if (fpos > 0)       fpos++;
      if (fpos > 0) check("busy_in_frame", int'(busy), 1);
      if (vsync_o) vs_len++;
      else if (vs_len != 0) begin
        check("vsync_len", vs_len, LINE_LEN * VSYNC_LINES);
        vs_len = 0;
      end
      if (href_o) begin
        h_len++;
        if (!prev_href) lines++;
      end else if (h_len != 0) begin
        check("href_len", h_len, 2 * H_ACTIVE);
        h_len = 0;
      end
      if (frame_done) begin
        check("frame_done_pos", fpos, FRAME_LEN);
        check("lines_per_frame", lines, V_ACTIVE);
        fpos = 0;
        lines = 0;
      end
      prev_vs = vsync_o;
      prev_href = href_o;
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      @(negedge cam_pclk);
      if (frame_done) begin
        ok = 1'b1;
        return;
      end
    end
    check("frame_done_timeout", 0, 1);
  endtask

  // Runs n frames back-to-back; fixed<4 selects one mode, otherwise random.
  // The next frame's mode (or junk on the last frame) is driven mid-frame.
  task automatic run_seq(input int n, input int fixed);
    int m;
    bit ok;
    m = (fixed < 4) ? fixed : int'($urandom_range(0, 3));
    @(negedge cam_pclk);
    mode = 2'(m);
    enable = 1'b1;
    push_frame(m);
    @(negedge cam_pclk);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 100)) @(negedge cam_pclk);
      m = (fixed < 4) ? fixed : int'($urandom_range(0, 3));
      if (k == n - 1) begin
        mode = 2'($urandom_range(0, 3));
        enable = 1'b0;
      end else begin
        mode = 2'(m);
        enable = 1'b1;
      end
      wait_done(ok);
      model_fcnt = (model_fcnt + 1) % 256;
      if (k < n - 1) push_frame(m);
    end
    @(negedge cam_pclk);
    check("busy_after_last", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge cam_pclk);
    check("rst_vsync", int'(vsync_o), 0);
    check("rst_href", int'(href_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Abort a frame in the middle of ACTIVE.
    @(negedge cam_pclk);
    mode = 2'd1;
    enable = 1'b1;
    push_frame(1);
    @(negedge cam_pclk);
    enable = 1'b0;
    for (int i = 0; i < 200 && !href_o; i++) @(negedge cam_pclk);
    check("href_seen", int'(href_o), 1);
    repeat (5) @(negedge cam_pclk);
    rst = 1'b1;
    #1;
    check("abort_vsync", int'(vsync_o), 0);
    check("abort_href", int'(href_o), 0);
    check("abort_data", int'(data_o), 0);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    model_fcnt = 0;
    repeat (2) @(negedge cam_pclk);
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge cam_pclk);
      if (vsync_o || href_o || busy || frame_done || data_o != 8'h00) bad++;
    end
    check("idle_200", bad, 0);

    run_seq(3, 2);
    run_seq(1, 1);
    run_seq(1, 0);
    run_seq(2, 3);
    run_seq(260, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
